instr_seq_ctrl: RTL and testbench
=================================

// Module: instr_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core. Owns the PC and the instruction register (IR).
//  Fetches over a req/valid instruction port and drives IR into the field decoder.
//  Reads the decoded opcode back and steps the datapath through EXEC/MEM/WB with
//  one-hot-in-time strobes. Traps on unsupported opcodes or misaligned jump/branch targets.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset; first fetch address
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  imem_req       out  1   instruction fetch request
//  imem_addr      out  32  fetch address (= pc)
//  imem_valid     in   1   fetch data valid; completes the request
//  imem_rdata     in   32  fetched instruction word
//  instruction    out  32  IR contents, drives the decoder
//  opcode         in   7   opcode field returned by the decoder
//  pc             out  32  current PC (to datapath for AUIPC/JAL link)
//  target_pc      in   32  branch/jump target computed by the datapath
//  branch_taken   in   1   branch compare result, sampled in EXEC
//  alu_en         out  1   execute strobe
//  dmem_req       out  1   data memory request
//  dmem_we        out  1   1 = store, 0 = load; valid while dmem_req
//  dmem_valid     in   1   data access complete
//  rf_we          out  1   register-file write enable (one cycle)
//  wb_sel         out  2   writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM_U
//  retire         out  1   one-cycle pulse when an instruction commits
//  illegal        out  1   sticky trap flag
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP), illegal=0; all strobes 0.
//  Reset is asynchronous and abandons any in-flight access. Memories share rst and drop pending responses.
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
//  FETCH: imem_req=1 and imem_addr=pc, held until imem_valid.
//    On imem_valid: IR<=imem_rdata, go to DECODE. imem_valid outside FETCH is ignored.
//  DECODE (1 cycle): classify opcode, which is stable from IR.
//    Legal opcodes: 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100011, 1101111, 1100111.
//    Any other opcode: illegal<=1, go to TRAP.
//  EXEC (1 cycle): alu_en=1. Register take_target = JAL | JALR | (BRANCH & branch_taken).
//    If take_target & target_pc[1:0]!=0: illegal<=1, go to TRAP; pc unchanged, no retire.
//    LOAD/STORE -> MEM. BRANCH -> commit. All other legal opcodes -> WB.
//  MEM: dmem_req=1, dmem_we=(STORE), both held until dmem_valid.
//    On dmem_valid: LOAD -> WB; STORE -> commit.
//  WB (1 cycle): rf_we=1, then commit. wb_sel by opcode:
//    LOAD=1; JAL/JALR=2; LUI=3; AUIPC/OP/OP-IMM=0.
//    wb_sel is driven valid in EXEC, MEM and WB; it is 0 elsewhere.
//  Commit happens in the same cycle as the last state (BRANCH in EXEC, STORE in MEM, others in WB):
//    retire=1; pc <= take_target ? target_pc : pc+32'd4 (mod 2^32, wrap silently); next state FETCH.
//  TRAP: terminal. No requests, no strobes, pc and IR frozen, illegal=1 until rst.
//  Latency with zero-wait memories, counted from the imem_req cycle:
//    ALU/LUI/AUIPC/JAL(R) = 4 cycles; BRANCH = 3; STORE = 4; LOAD = 5.
//  Back-to-back: FETCH of the next instruction starts the cycle after retire.
//  Stall/boundary: arbitrarily long waits in FETCH/MEM are legal; no timeout.
//    Outputs stay stable while waiting. pc=32'hFFFF_FFFC + 4 wraps to 0.
// TESTING
//  1. rst pulse, imem returns 0x00500093 (addi) next cycle -> imem_addr=0; alu_en@3, rf_we+retire@4 with wb_sel=0; pc=4.
//  2. lw (0x0000A103), dmem_valid 3 cycles late -> dmem_req/dmem_we=0 held 4 cycles; rf_we with wb_sel=1; retire; pc+=4.
//  3. beq with branch_taken=1, target_pc=0x40 -> retire in EXEC cycle, no rf_we; next imem_addr=0x40. Repeat with taken=0 -> pc+4.
//  4. jal, target_pc=0x102 (misaligned) -> illegal=1, state TRAP, no retire, imem_req stays 0 for 20+ cycles.
//  5. opcode 0x7F -> illegal set in the DECODE cycle; a later rst clears illegal and refetches from RESET_PC.
//  6. rst asserted mid-MEM with dmem_req=1 -> all outputs drop immediately (asynchronous); after release, FETCH at RESET_PC.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle RV32I fetch/decode/exec/mem/wb sequencer with sticky trap
module instr_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic [6:0]  opcode,
  output logic [31:0] pc,
  input  logic [31:0] target_pc,
  input  logic        branch_taken,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_valid,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;
  logic [2:0]  state, state_n;
  logic [31:0] tgt_q, next_tgt;
  logic        take_q, take_now, take, misalign, commit, legal;
  logic        is_op, is_opi, is_ld, is_st, is_lui, is_aui, is_br, is_jal, is_jalr;
  logic        in_fetch, in_decode, in_exec, in_mem, in_wb;
  assign in_fetch  = state == S_FETCH;
  assign in_decode = state == S_DECODE;
  assign in_exec   = state == S_EXEC;
  assign in_mem    = state == S_MEM;
  assign in_wb     = state == S_WB;
  assign is_op   = opcode == 7'b0110011;
  assign is_opi  = opcode == 7'b0010011;
  assign is_ld   = opcode == 7'b0000011;
  assign is_st   = opcode == 7'b0100011;
  assign is_lui  = opcode == 7'b0110111;
  assign is_aui  = opcode == 7'b0010111;
  assign is_br   = opcode == 7'b1100011;
  assign is_jal  = opcode == 7'b1101111;
  assign is_jalr = opcode == 7'b1100111;
  assign legal   = is_op | is_opi | is_ld | is_st | is_lui | is_aui | is_br | is_jal | is_jalr;
  assign take_now = is_jal | is_jalr | (is_br & branch_taken);
  assign misalign = take_now & (target_pc[1:0] != 2'b00);
  assign take     = in_exec ? take_now : take_q;
  assign next_tgt = in_exec ? target_pc : tgt_q;
  assign commit   = (in_exec & is_br & ~misalign) | (in_mem & is_st & dmem_valid) | in_wb;
  assign imem_req    = in_fetch & ~rst;
  assign imem_addr   = pc;
  assign alu_en      = in_exec;
  assign dmem_req    = in_mem;
  assign dmem_we     = in_mem & is_st;
  assign rf_we       = in_wb;
  assign retire      = commit;
  assign wb_sel      = ~(in_exec | in_mem | in_wb) ? 2'd0 : is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
  // next-state selection; TRAP only leaves through reset
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  state_n = imem_valid ? S_DECODE : S_FETCH;
      S_DECODE: state_n = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_n = misalign ? S_TRAP : (is_ld | is_st) ? S_MEM : is_br ? S_FETCH : S_WB;
      S_MEM:    state_n = ~dmem_valid ? S_MEM : is_ld ? S_WB : S_FETCH;
      S_WB:     state_n = S_FETCH;
      default:  state_n = S_TRAP;
    endcase
  end
  // sequencer state, IR, PC, registered jump decision and sticky trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instruction <= 32'h0000_0013;
      take_q      <= 1'b0;
      tgt_q       <= 32'd0;
      illegal     <= 1'b0;
    end else begin
      state <= state_n;
      if (in_fetch & imem_valid) instruction <= imem_rdata;
      if (in_exec) begin
        take_q <= take_now;
        tgt_q  <= target_pc;
      end
      if (commit) pc <= take ? next_tgt : pc + 32'd4;
      if ((in_decode & ~legal) | (in_exec & misalign)) illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed and randomized per-instruction checks against a transaction-level model
module tb_instr_seq_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 0, rst = 0;
  logic        imem_req, imem_valid = 0, dmem_req, dmem_we, dmem_valid = 0;
  logic [31:0] imem_addr, imem_rdata = 0, instruction, pc, target_pc = 0;
  logic [6:0]  opcode;
  logic        branch_taken = 0, alu_en, rf_we, retire, illegal;
  logic [1:0]  wb_sel;
  int          n_vec = 0, n_bad = 0;
  logic [31:0] m_pc;
  logic        m_ill;
  logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};

  instr_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instruction(instruction), .opcode(opcode), .pc(pc),
    .target_pc(target_pc), .branch_taken(branch_taken), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_valid(dmem_valid), .rf_we(rf_we), .wb_sel(wb_sel),
    .retire(retire), .illegal(illegal)
  );

  assign opcode = instruction[6:0];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic want(input string tag, input logic ir, input logic ae, input logic dr, input logic dw,
                      input logic rw, input logic [1:0] ws, input logic rt);
    chk(tag, {23'd0, imem_req, imem_addr, pc, alu_en, dmem_req, dmem_we, rf_we, wb_sel, retire, illegal},
             {23'd0, ir, m_pc, m_pc, ae, dr, dw, rw, ws, rt, m_ill});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    imem_valid = 0;
    dmem_valid = 0;
    m_pc = RESET_PC;
    m_ill = 0;
    #3;
    want("reset", 0, 0, 0, 0, 0, 2'd0, 0);
    chk("reset_ir", {64'd0, instruction}, {64'd0, 32'h0000_0013});
    @(negedge clk);
    rst = 0;
    step;
  endtask

  task automatic trap(input logic [31:0] ins, input int n);
    for (int i = 0; i < n; i++) begin
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      dmem_valid = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      want("trap", 0, 0, 0, 0, 0, 2'd0, 0);
      chk("trap_ir", {64'd0, instruction}, {64'd0, ins});
      step;
    end
    imem_valid = 0;
    dmem_valid = 0;
  endtask

  // one instruction from fetch to commit; ab >= 0 asserts rst in that MEM wait cycle
  task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic tk,
                     input logic [31:0] tg, input int ab);
    logic [6:0] op;
    logic ld, st, br, jl, leg, take, mis;
    logic [1:0] ws;
    op  = ins[6:0];
    ld  = op == 7'h03;
    st  = op == 7'h23;
    br  = op == 7'h63;
    jl  = op == 7'h6F || op == 7'h67;
    leg = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};
    ws  = ld ? 2'd1 : jl ? 2'd2 : op == 7'h37 ? 2'd3 : 2'd0;
    take = jl || (br && tk);
    mis  = take && tg[1:0] != 2'b00;
    for (int i = 0; i <= fw; i++) begin
      imem_valid = i == fw;
      imem_rdata = i == fw ? ins : $urandom;
      dmem_valid = 1'($urandom);
      #1;
      want("fetch", 1, 0, 0, 0, 0, 2'd0, 0);
      step;
    end
    imem_valid = 0;
    imem_rdata = $urandom;
    dmem_valid = 0;
    #1;
    want("decode", 0, 0, 0, 0, 0, 2'd0, 0);
    chk("ir", {64'd0, instruction}, {64'd0, ins});
    step;
    if (!leg) begin
      m_ill = 1;
      trap(ins, 6);
      return;
    end
    target_pc = tg;
    branch_taken = tk;
    #1;
    want("exec", 0, 1, 0, 0, 0, ws, br && !mis);
    step;
    if (mis) begin
      m_ill = 1;
      trap(ins, 22);
      return;
    end
    if (br) begin
      m_pc = take ? tg : m_pc + 32'd4;
      return;
    end
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        dmem_valid = i == mw;
        #1;
        want("mem", 0, 0, 1, st, 0, ws, st && i == mw);
        if (i == ab) begin
          #1;
          rst = 1;
          m_pc = RESET_PC;
          m_ill = 0;
          #1;
          want("async_rst", 0, 0, 0, 0, 0, 2'd0, 0);
          return;
        end
        step;
      end
      dmem_valid = 0;
      if (st) begin
        m_pc = m_pc + 32'd4;
        return;
      end
    end
    #1;
    want("wb", 0, 0, 0, 0, 1, ws, 1);
    step;
    m_pc = take ? tg : m_pc + 32'd4;
  endtask

  initial begin
    logic [31:0] r, ins;
    do_reset;
    run(32'h0050_0093, 0, 0, 0, 32'h0, -1);
    run(32'h0000_A103, 0, 3, 0, 32'h0, -1);
    run(32'h0000_0063, 0, 0, 1, 32'h40, -1);
    run(32'h0000_0063, 2, 0, 0, 32'h80, -1);
    run(32'h0000_006F, 0, 0, 0, 32'hFFFF_FFFC, -1);
    run(32'h0050_0093, 1, 0, 0, 32'h0, -1);
    run(32'h0020_A023, 0, 2, 1, 32'h123, -1);
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      ins = {r[31:7], legal_ops[$urandom_range(0, 8)]};
      run(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom & 32'hFFFF_FFFC, -1);
    end
    run(32'h0000_006F, 0, 0, 0, 32'h102, -1);
    do_reset;
    run(32'h0000_007F, 0, 0, 0, 32'h0, -1);
    do_reset;
    run(32'h0050_0093, 0, 0, 0, 32'h0, -1);
    run(32'h0000_A103, 1, 5, 0, 32'h0, 2);
    do_reset;
    run(32'h0050_0093, 0, 0, 0, 32'h0, -1);
    for (int n = 0; n < 6; n++) begin
      r = $urandom;
      ins = r;
      while (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67}) ins[6:0] = 7'($urandom);
      run(ins, $urandom_range(0, 2), 0, 0, 32'h0, -1);
      do_reset;
      run(32'h0000_0067 | (r & 32'hFFFF_F000), 0, 0, 0, {r[31:2], 2'b00} | 32'(n % 3 + 1), -1);
      do_reset;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
